// File: rtl/uart_tx_feed_pkg.sv
// uart_tx_feed_pkg: state encoding and constants shared by the UART TX feeder and its FIFO.
package uart_tx_feed_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    WAIT_ACK  = 2'b10,
    WAIT_DONE = 2'b11
  } state_t;
  localparam int ACK_TIMEOUT = 2;
  localparam int DROP_W = 8;
endpackage

// File: rtl/uart_tx_sync_fifo.sv
// uart_tx_sync_fifo: synchronous FIFO with wrap-bit pointers and registered FULL/EMPTY/COUNT.
module uart_tx_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_en_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_W:0]       count_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q;
  logic full_q, empty_q, wr;
  // FULL is the pre-pop flag, so a write colliding with a pop on a full FIFO is still dropped
  assign wr = wr_en_i && !full_q;
  assign wr_ptr_d = wr ? wr_ptr_q + (ADDR_W+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = (pop_i && !empty_q) ? rd_ptr_q + (ADDR_W+1)'(1) : rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign full_o = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;
  always_ff @(posedge CLK)
    if (wr) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) && (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
      empty_q  <= wr_ptr_d == rd_ptr_d;
      count_q  <= wr_ptr_d - rd_ptr_d;
    end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO-backed issue stage keeping exactly one UART frame in flight.
// Define UART_TX_FEEDER_DROP_CNT_EN to add DROP_CNT, a saturating count of writes refused while full.
module uart_tx_feeder
  import uart_tx_feed_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_W:0]       FIFO_COUNT,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_DATA_VALID
`ifdef UART_TX_FEEDER_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0]     DROP_CNT
`endif
);
  state_t state_q;
  logic [1:0] ack_cnt_q;
  logic [DATA_WIDTH-1:0] data_q, head;
  logic valid_q, pop;
  assign pop = (state_q == IDLE) && !EMPTY && !TX_BUSY;
  assign TX_P_DATA = data_q;
  assign TX_DATA_VALID = valid_q;
  uart_tx_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .CLK(CLK),
    .RST(RST),
    .wr_data_i(WR_DATA),
    .wr_en_i(WR_EN),
    .pop_i(pop),
    .rd_data_o(head),
    .full_o(FULL),
    .empty_o(EMPTY),
    .count_o(FIFO_COUNT)
  );
  // A missing busy acknowledge still consumes the byte; it is never re-issued
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q   <= IDLE;
      ack_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (pop) begin
          state_q <= ISSUE;
          data_q  <= head;
          valid_q <= 1'b1;
        end
        ISSUE: begin
          state_q   <= WAIT_ACK;
          ack_cnt_q <= '0;
        end
        WAIT_ACK:
          if (TX_BUSY) state_q <= WAIT_DONE;
          else if (ack_cnt_q == 2'(ACK_TIMEOUT - 1)) state_q <= IDLE;
          else ack_cnt_q <= ack_cnt_q + 2'd1;
        WAIT_DONE: if (!TX_BUSY) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
`ifdef UART_TX_FEEDER_DROP_CNT_EN
  logic [DROP_W-1:0] drop_q;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) drop_q <= '0;
    else if (WR_EN && FULL && drop_q != '1) drop_q <= drop_q + DROP_W'(1);
  assign DROP_CNT = drop_q;
`endif
endmodule
